// File: rtl/frame_extremum_tracker.sv
// Frame max/min tracker driving an external combinational 8-bit magnitude comparator.
// Reports the max/min of each FRAME_LEN-sample frame and the first index of each.
module frame_extremum_tracker #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic              iData_valid,
    input  logic [DATA_W-1:0] iData,
    output logic              oData_ready,
    output logic [DATA_W-1:0] oCmp_a,
    output logic [DATA_W-1:0] oCmp_b,
    input  logic [2:0]        iCmp_res,
    output logic [DATA_W-1:0] oMax,
    output logic [DATA_W-1:0] oMin,
    output logic [IDX_W-1:0]  oMax_idx,
    output logic [IDX_W-1:0]  oMin_idx,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    typedef enum logic [2:0] {
        S_IDLE, S_FIRST, S_WAIT, S_CMP_MAX, S_CMP_MIN, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic [IDX_W-1:0]  r_max_idx;
    logic [IDX_W-1:0]  r_min_idx;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_err;

    logic w_hs;
    logic w_gt;
    logic w_lt;
    logic w_eq;
    logic w_bad;
    logic w_in_cmp;

    // Anything other than a single set bit is an illegal code and never updates.
    assign w_gt     = (iCmp_res == 3'b100);
    assign w_lt     = (iCmp_res == 3'b010);
    assign w_eq     = (iCmp_res == 3'b001);
    assign w_bad    = !(w_gt || w_lt || w_eq);
    assign w_in_cmp = (r_state == S_CMP_MAX) || (r_state == S_CMP_MIN);

    assign oData_ready = (r_state == S_FIRST) || (r_state == S_WAIT);
    assign oBusy       = oData_ready || w_in_cmp;
    assign w_hs        = iData_valid && oData_ready;

    assign oCmp_a   = w_in_cmp ? r_sample : '0;
    assign oCmp_b   = (r_state == S_CMP_MAX) ? r_max :
                      (r_state == S_CMP_MIN) ? r_min : '0;
    assign oMax     = r_max;
    assign oMin     = r_min;
    assign oMax_idx = r_max_idx;
    assign oMin_idx = r_min_idx;
    assign oDone    = r_done;
    assign oErr     = r_err;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state   <= S_IDLE;
            r_sample  <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        r_state   <= S_FIRST;
                        r_max     <= '0;
                        r_min     <= '0;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_cnt     <= '0;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                S_FIRST: begin
                    if (w_hs) begin
                        r_max     <= iData;
                        r_min     <= iData;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_cnt     <= IDX_W'(1);
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_hs) begin
                        r_sample <= iData;
                        r_state  <= S_CMP_MAX;
                    end
                end
                S_CMP_MAX: begin
                    if (w_gt) begin
                        r_max     <= r_sample;
                        r_max_idx <= r_cnt;
                    end
                    if (w_bad) r_err <= 1'b1;
                    r_state <= S_CMP_MIN;
                end
                S_CMP_MIN: begin
                    if (w_lt) begin
                        r_min     <= r_sample;
                        r_min_idx <= r_cnt;
                    end
                    if (w_bad) r_err <= 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_extremum_tracker.sv
// Directed bench for frame_extremum_tracker with a behavioural comparator and
// a result scoreboard filled when a frame is driven and drained at oDone.
module tb_frame_extremum_tracker;

    typedef logic [7:0] frame_t [16];
    typedef struct packed {
        logic [7:0] mx;
        logic [7:0] mn;
        logic [3:0] mxi;
        logic [3:0] mni;
        logic       err;
    } res_t;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iStart;
    logic       iData_valid;
    logic [7:0] iData;
    logic       oData_ready;
    logic [7:0] oCmp_a;
    logic [7:0] oCmp_b;
    logic [2:0] iCmp_res;
    logic [7:0] oMax;
    logic [7:0] oMin;
    logic [3:0] oMax_idx;
    logic [3:0] oMin_idx;
    logic       oBusy;
    logic       oDone;
    logic       oErr;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   hs_cnt   = 0;
    bit   bad_en   = 1'b0;
    int   bad_idx  = 6;
    res_t sb[$];

    frame_extremum_tracker #(
        .DATA_W(8),
        .FRAME_LEN(16),
        .IDX_W(4)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .iData_valid(iData_valid), .iData(iData), .oData_ready(oData_ready),
        .oCmp_a(oCmp_a), .oCmp_b(oCmp_b), .iCmp_res(iCmp_res),
        .oMax(oMax), .oMin(oMin), .oMax_idx(oMax_idx), .oMin_idx(oMin_idx),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // Handshakes within the current frame; the sample under comparison has index hs_cnt-1.
    always @(posedge iClk) begin
        if (iStart && !oBusy) hs_cnt <= 0;
        else if (iData_valid && oData_ready) hs_cnt <= hs_cnt + 1;
    end

    always_comb begin
        if (bad_en && hs_cnt == bad_idx + 1) iCmp_res = 3'b000;
        else if (oCmp_a > oCmp_b)            iCmp_res = 3'b100;
        else if (oCmp_a < oCmp_b)            iCmp_res = 3'b010;
        else                                 iCmp_res = 3'b001;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t golden(input frame_t f, input bit skip_bad);
        res_t r;
        r.mx = f[0]; r.mn = f[0]; r.mxi = '0; r.mni = '0; r.err = skip_bad;
        for (int i = 1; i < 16; i++) begin
            if (!(skip_bad && i == bad_idx)) begin
                if (f[i] > r.mx) begin r.mx = f[i]; r.mxi = 4'(i); end
                if (f[i] < r.mn) begin r.mn = f[i]; r.mni = 4'(i); end
            end
        end
        return r;
    endfunction

    // Called at a negedge; returns at a negedge after n handshakes.
    task automatic send_frame(input frame_t f, input int n, input int pct,
                              input bit mid_start, output int t0);
        int i;
        int guard;
        bit hs;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        check("start_busy", oBusy, 1);
        check("start_done_clr", oDone, 0);
        check("start_err_clr", oErr, 0);
        check("start_max_clr", {oMax, oMin, oMax_idx, oMin_idx}, 0);
        if (n == 16) sb.push_back(golden(f, bad_en));
        i = 0; guard = 0; t0 = 0;
        while (i < n && guard < 1000) begin
            iData       = f[i];
            iData_valid = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            iStart      = mid_start && (i == 5);
            hs          = iData_valid && oData_ready;
            if (hs && i == 0) t0 = cyc;
            @(negedge iClk);
            guard++;
            if (hs) i++;
        end
        iData_valid = 1'b0;
        iStart      = 1'b0;
        if (i < n) check("send_timeout", i, n);
    endtask

    task automatic wait_done(output int t1);
        int guard;
        res_t e;
        guard = 0;
        while (!oDone && guard < 200) begin
            @(negedge iClk);
            guard++;
        end
        t1 = cyc;
        check("done_seen", oDone, 1);
        if (sb.size() == 0) begin
            check("sb_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check("max", oMax, e.mx);
            check("max_idx", oMax_idx, e.mxi);
            check("min", oMin, e.mn);
            check("min_idx", oMin_idx, e.mni);
            check("err", oErr, e.err);
        end
        check("done_ready", oData_ready, 0);
        check("done_busy", oBusy, 0);
        check("done_cmp", {oCmp_a, oCmp_b}, 0);
    endtask

    initial begin
        frame_t f;
        int t0;
        int t1;
        iRst_n = 1'b0; iStart = 1'b0; iData_valid = 1'b0; iData = '0;
        #1;
        check("rst_outs", {oMax, oMin, oMax_idx, oMin_idx, oDone, oErr, oBusy, oData_ready}, 0);
        check("rst_cmp", {oCmp_a, oCmp_b}, 0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);

        // Ascending frame with continuous valid; latency from first handshake.
        for (int i = 0; i < 16; i++) f[i] = 8'(i + 1);
        send_frame(f, 16, 100, 1'b0, t0);
        wait_done(t1);
        check("latency", t1 - t0, 46);
        check("asc_max", oMax, 16);
        check("asc_min_idx", oMin_idx, 0);
        repeat (3) @(negedge iClk);
        check("done_held", oDone, 1);

        // Ties keep the first occurrence.
        for (int i = 0; i < 16; i++) f[i] = 8'd4;
        f[0] = 8'd5; f[1] = 8'd9; f[2] = 8'd9; f[3] = 8'd2; f[4] = 8'd2; f[5] = 8'd7;
        send_frame(f, 16, 100, 1'b0, t0);
        wait_done(t1);
        check("tie_max_idx", oMax_idx, 1);
        check("tie_min_idx", oMin_idx, 3);

        // Illegal comparator code on sample 6.
        for (int i = 0; i < 16; i++) f[i] = 8'($urandom_range(1, 254));
        f[6] = 8'd255;
        bad_en = 1'b1;
        send_frame(f, 16, 100, 1'b0, t0);
        wait_done(t1);
        bad_en = 1'b0;
        check("bad_err", oErr, 1);

        // Random valid gaps and a mid-frame iStart; the start check confirms oErr cleared.
        for (int i = 0; i < 16; i++) f[i] = 8'($urandom_range(0, 255));
        send_frame(f, 16, 40, 1'b1, t0);
        wait_done(t1);

        // Async reset partway through a frame.
        for (int i = 0; i < 16; i++) f[i] = 8'(200 - 10 * i);
        send_frame(f, 9, 100, 1'b0, t0);
        #2 iRst_n = 1'b0;
        #1;
        check("midrst_outs", {oMax, oMin, oMax_idx, oMin_idx, oDone, oErr, oBusy, oData_ready}, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        for (int i = 0; i < 16; i++) f[i] = 8'hAA;
        send_frame(f, 16, 100, 1'b0, t0);
        wait_done(t1);
        check("aa_all", {oMax, oMin, oMax_idx, oMin_idx}, {8'hAA, 8'hAA, 4'd0, 4'd0});

        // Back-to-back frames restarted straight from DONE.
        for (int i = 0; i < 16; i++) f[i] = 8'(255 - i);
        send_frame(f, 16, 100, 1'b0, t0);
        wait_done(t1);
        for (int i = 0; i < 16; i++) f[i] = 8'(50 + ((i * 7) % 16));
        send_frame(f, 16, 100, 1'b0, t0);
        wait_done(t1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_extremum_tracker.md
Name: frame_extremum_tracker

Overview:
Sequential stage wrapped around the team's 8-bit magnitude comparator. It accepts a frame of FRAME_LEN samples over a valid/ready handshake. For each sample it drives the comparator operands and consumes the 3-bit one-hot result code (100 = a>b, 010 = a<b, 001 = a==b). At the end of the frame it reports the maximum and minimum values and the index of each.

Parameters:
DATA_W, 8, sample width; must equal the comparator width (8)
FRAME_LEN, 16, samples per frame, legal range 2..256
IDX_W, 4, index/counter width, equal to clog2(FRAME_LEN)

Ports:
iClk  in  1  system clock, rising edge
iRst_n  in  1  asynchronous active-low reset
iStart  in  1  start a new frame; sampled only in IDLE or DONE
iData_valid  in  1  upstream sample valid
iData  in  DATA_W  upstream sample
oData_ready  out  1  block accepts a sample when iData_valid&oData_ready
oCmp_a  out  DATA_W  comparator operand a (current sample)
oCmp_b  out  DATA_W  comparator operand b (running max or min)
iCmp_res  in  3  comparator result code {gt,lt,eq}, combinational from oCmp_a/oCmp_b
oMax  out  DATA_W  frame maximum
oMin  out  DATA_W  frame minimum
oMax_idx  out  IDX_W  index of the first occurrence of the maximum
oMin_idx  out  IDX_W  index of the first occurrence of the minimum
oBusy  out  1  frame in progress
oDone  out  1  results valid; level held until the next accepted iStart
oErr  out  1  sticky illegal-result-code flag

Behaviour:
- Reset (async, iRst_n=0): state=IDLE; all outputs and internal registers are 0.
- Reset mid-frame discards the frame. No partial result is reported.
- States: IDLE, FIRST, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE/DONE: oData_ready=0, oBusy=0. iStart=1 -> FIRST. The same edge clears oDone, oErr, the sample counter, oMax, oMin and both indices.
- FIRST: oData_ready=1, oBusy=1. On handshake: max=min=iData, both indices=0, cnt=1 -> WAIT.
- WAIT: oData_ready=1. On handshake: iData is latched into the sample register -> CMP_MAX. With no valid, the block stays in WAIT indefinitely.
- CMP_MAX: oData_ready=0, oCmp_a=sample, oCmp_b=max. At the clock edge:
  - res=100: max<=sample, max_idx<=cnt.
  - res=010 or 001: no change, so ties keep the first index.
  - Next state: CMP_MIN.
- CMP_MIN: oCmp_a=sample, oCmp_b=min.
  - res=010: min<=sample, min_idx<=cnt.
  - res=100 or 001: no change.
  - cnt<=cnt+1. If cnt==FRAME_LEN-1 -> DONE with oDone<=1, else -> WAIT.
- Each comparison uses a single cycle. The comparator is combinational and the result is sampled on the same edge.
- Throughput: one sample per 3 cycles after the first. Frame latency with continuous valid is 1+3*(FRAME_LEN-1) cycles from the FIRST handshake to oDone.
- oCmp_a and oCmp_b are 0 outside CMP_MAX and CMP_MIN.
- Illegal code (not exactly one of 100/010/001): treated as no-update. oErr is set and stays set until the next accepted iStart. The FSM still advances.
- iStart while busy (FIRST, WAIT, CMP_*): ignored.
- iStart in DONE: results are cleared and the next frame begins immediately.
- oMax, oMin and the indices update live during the frame. They are valid only while oDone=1.
- cnt is IDX_W bits wide. It never wraps within a frame because the DONE transition fires at FRAME_LEN-1.
- All values are unsigned.

Test Plan:
1. Ascending frame 1..16 with continuous valid, behavioural comparator model.
   -> oMax=16, oMax_idx=15, oMin=1, oMin_idx=0, oErr=0.
   -> oDone rises 46 cycles after the FIRST handshake.
2. Frame {5,9,9,2,2,7,...} with the remaining samples set to 4.
   -> oMax=9, oMax_idx=1; oMin=2, oMin_idx=3 (first occurrence wins on ties).
3. Comparator model forced to return 3'b000 on sample 6 of a random frame.
   -> oErr=1 at DONE; the extremes ignore sample 6; the next iStart clears oErr.
4. iData_valid toggled at random, iStart pulsed mid-frame.
   -> Only handshaked samples are counted; the mid-frame iStart is ignored; the result matches the golden model.
5. Async reset after sample 8 of a frame, then a new frame of all 0xAA.
   -> All outputs go to 0 immediately; the second frame gives oMax=oMin=0xAA with both indices 0.
6. iStart held in DONE with back-to-back frames.
   -> oDone clears on the restart edge; the second frame's result is independent of the first.
